// File: rtl/imgproc_stream.sv
// -----------------------------------------------------------------------------
// imgproc_stream
//   Streams an IMG_W x IMG_H frame of packed 24-bit RGB pixels from a pattern
//   memory (request / orig_ready handshake) and emits one processed 8-bit pixel
//   per input pixel towards a result memory, then raises finish.
//
//   Modes (latched on start): 0 average, 1 luminance, 2 max channel,
//   3 luminance thresholded against THRESH.
//
//   Pipeline: accept register -> stage 1 (sum / products / max)
//             -> stage 2 (mode select, output register).
//   A pixel accepted at edge k is presented with imgproc_ready=1 after k+2.
//
// Ports
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle pulse, honoured only in IDLE or DONE
//   mode[1:0]      processing mode, sampled with start
//   orig_data[23:0]{R,G,B} pixel for orig_addr
//   orig_ready     orig_data valid this cycle
//   request        read request for orig_addr
//   orig_addr      input pixel index (raster order)
//   imgproc_ready  one-cycle pulse: imgproc_addr/imgproc_data valid
//   imgproc_addr   output pixel index
//   imgproc_data   processed pixel
//   finish         frame complete, held until the next start
// -----------------------------------------------------------------------------
module imgproc_stream #(
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int WAIT_LIMIT = 4,
    parameter int THRESH     = 128,
    localparam int AW        = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [23:0]   orig_data,
    input  logic          orig_ready,
    output logic          request,
    output logic [AW-1:0] orig_addr,
    output logic          imgproc_ready,
    output logic [AW-1:0] imgproc_addr,
    output logic [7:0]    imgproc_data,
    output logic          finish
);

    localparam int            N    = IMG_W * IMG_H;
    localparam int            WW   = $clog2(WAIT_LIMIT + 1);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic            w_request, w_finish;
    logic            w_start_ok, w_accept, w_last;

    logic [WW-1:0]   r_wait;
    logic [AW-1:0]   r_orig_addr;
    logic [1:0]      r_mode;

    // accept register
    logic            r_v0;
    logic [23:0]     r_pix0;
    logic [AW-1:0]   r_a0;
    // stage 1
    logic            r_v1;
    logic [9:0]      r_sum1;
    logic [15:0]     r_lum1;
    logic [7:0]      r_max1;
    logic [AW-1:0]   r_a1;
    // stage 2 (output)
    logic            r_rdy2;
    logic [AW-1:0]   r_a2;
    logic [7:0]      r_data2;

    logic [15:0]     w_r16, w_g16, w_b16, w_lum;
    logic [9:0]      w_sum;
    logic [7:0]      w_max;
    logic [7:0]      w_result;

    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
    // A withheld pixel is forced through once the wait counter reaches the limit.
    assign w_accept   = (r_state == S_FETCH) && (orig_ready || r_wait == WW'(WAIT_LIMIT));
    assign w_last     = w_accept && (r_orig_addr == LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_FETCH;
            S_FETCH: if (w_last) w_state_next = S_DRAIN;
            // Both pipeline stages empty means the last output is on the bus now.
            S_DRAIN: if (!r_v0 && !r_v1) w_state_next = S_DONE;
            S_DONE:  if (start) w_state_next = S_FETCH;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_request = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            S_FETCH: w_request = 1'b1;
            S_DONE:  w_finish  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- fetch side ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait      <= '0;
            r_orig_addr <= '0;
            r_mode      <= 2'd0;
        end else begin
            if (w_start_ok) begin
                r_wait      <= '0;
                r_orig_addr <= '0;
                r_mode      <= mode;
            end else begin
                if (w_accept)
                    r_wait <= '0;
                else if (r_state == S_FETCH && !orig_ready)
                    r_wait <= r_wait + WW'(1);
                if (w_accept)
                    r_orig_addr <= w_last ? '0 : r_orig_addr + AW'(1);
            end
        end
    end

    // ---------------- stage 1 arithmetic ----------------
    assign w_r16 = {8'd0, r_pix0[23:16]};
    assign w_g16 = {8'd0, r_pix0[15:8]};
    assign w_b16 = {8'd0, r_pix0[7:0]};
    assign w_lum = 16'd77 * w_r16 + 16'd150 * w_g16 + 16'd29 * w_b16;
    assign w_sum = {2'b00, r_pix0[23:16]} + {2'b00, r_pix0[15:8]} + {2'b00, r_pix0[7:0]};

    always_comb begin
        w_max = r_pix0[23:16];
        if (r_pix0[15:8] > w_max) w_max = r_pix0[15:8];
        if (r_pix0[7:0]  > w_max) w_max = r_pix0[7:0];
    end

    // ---------------- stage 2 mode select ----------------
    always_comb begin
        w_result = 8'd0;
        case (r_mode)
            2'd0: w_result = 8'(r_sum1 / 10'd3);
            2'd1: w_result = 8'(r_lum1 >> 8);
            2'd2: w_result = r_max1;
            2'd3: w_result = ((r_lum1 >> 8) >= 16'(THRESH)) ? 8'hFF : 8'h00;
            default: w_result = 8'd0;
        endcase
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0    <= 1'b0;
            r_pix0  <= '0;
            r_a0    <= '0;
            r_v1    <= 1'b0;
            r_sum1  <= '0;
            r_lum1  <= '0;
            r_max1  <= '0;
            r_a1    <= '0;
            r_rdy2  <= 1'b0;
            r_a2    <= '0;
            r_data2 <= '0;
        end else begin
            r_v0 <= w_accept;
            if (w_accept) begin
                r_pix0 <= orig_ready ? orig_data : 24'h000000;
                r_a0   <= r_orig_addr;
            end
            r_v1 <= r_v0;
            if (r_v0) begin
                r_sum1 <= w_sum;
                r_lum1 <= w_lum;
                r_max1 <= w_max;
                r_a1   <= r_a0;
            end
            r_rdy2 <= r_v1;
            if (r_v1) begin
                r_data2 <= w_result;
                r_a2    <= r_a1;
            end
        end
    end

    assign request       = w_request;
    assign finish        = w_finish;
    assign orig_addr     = r_orig_addr;
    assign imgproc_ready = r_rdy2;
    assign imgproc_addr  = r_a2;
    assign imgproc_data  = r_data2;

endmodule

// File: tb/tb_imgproc_stream.sv
module tb_imgproc_stream;

    localparam int BN  = 128 * 128;
    localparam int BAW = $clog2(BN);
    localparam int SN  = 8;
    localparam int SAW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_px(input logic [1:0] m, input logic [23:0] p);
        int r, g, b, l, mx;
        r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
        l = (77 * r + 150 * g + 29 * b) / 256;
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        case (m)
            2'd0:    return 8'((r + g + b) / 3);
            2'd1:    return 8'(l);
            2'd2:    return 8'(mx);
            default: return (l >= 128) ? 8'hFF : 8'h00;
        endcase
    endfunction

    // ---------------- default-size instance ----------------
    logic            b_rst = 1'b1, b_start = 1'b0;
    logic [1:0]      b_mode = 2'd0;
    logic [23:0]     b_data;
    logic            b_oready;
    logic            b_req, b_irdy, b_fin;
    logic [BAW-1:0]  b_oaddr, b_iaddr;
    logic [7:0]      b_idata;

    assign b_data   = {b_oaddr[7:0], 8'h10, 8'h20};
    assign b_oready = 1'b1;

    imgproc_stream #(.IMG_W(128), .IMG_H(128), .WAIT_LIMIT(4), .THRESH(128)) u_big (
        .clk(clk), .rst(b_rst), .start(b_start), .mode(b_mode),
        .orig_data(b_data), .orig_ready(b_oready), .request(b_req),
        .orig_addr(b_oaddr), .imgproc_ready(b_irdy), .imgproc_addr(b_iaddr),
        .imgproc_data(b_idata), .finish(b_fin)
    );

    // ---------------- 4x2 instance ----------------
    logic            s_rst = 1'b1, s_start = 1'b0;
    logic [1:0]      s_mode = 2'd0;
    logic [23:0]     s_pix [SN];
    logic [23:0]     s_data;
    logic            s_oready, s_stall = 1'b0;
    logic            s_req, s_irdy, s_fin;
    logic [SAW-1:0]  s_oaddr, s_iaddr;
    logic [7:0]      s_idata;

    assign s_data   = s_pix[s_oaddr];
    assign s_oready = !(s_stall && s_oaddr == 3'd5);

    imgproc_stream #(.IMG_W(4), .IMG_H(2), .WAIT_LIMIT(4), .THRESH(128)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .mode(s_mode),
        .orig_data(s_data), .orig_ready(s_oready), .request(s_req),
        .orig_addr(s_oaddr), .imgproc_ready(s_irdy), .imgproc_addr(s_iaddr),
        .imgproc_data(s_idata), .finish(s_fin)
    );

    // ---------------- output monitors (negedge sampling) ----------------
    int         b_idx = 0;
    int         s_idx = 0;
    logic [7:0] s_out [SN];

    always @(negedge clk) begin
        if (b_irdy) begin
            check("big_order", 32'(b_iaddr), b_idx);
            check("big_value", 32'(b_idata), ((b_idx & 255) + 48) / 3);
            b_idx++;
        end
    end

    always @(negedge clk) begin
        if (s_irdy) begin
            check("small_order", 32'(s_iaddr), s_idx);
            s_out[s_iaddr] = s_idata;
            s_idx++;
        end
    end

    // ---------------- small-frame helper ----------------
    int   s_cyc;
    logic s_req0, s_fin0;
    logic [SAW-1:0] s_addr0;

    task automatic s_frame(input logic [1:0] m, input bit pulse_mid);
        for (int i = 0; i < SN; i++) s_out[i] = 'x;
        s_idx  = 0;
        s_mode = m;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        s_req0  = s_req;
        s_addr0 = s_oaddr;
        s_fin0  = s_fin;
        s_cyc   = 0;
        while (!s_fin && s_cyc < 200) begin
            @(posedge clk); #1;
            s_cyc++;
            if (pulse_mid && s_cyc == 3) begin
                s_start = 1'b1;
                s_mode  = ~m;
            end else begin
                s_start = 1'b0;
            end
        end
    endtask

    int big_cyc;
    int rdy_seen;
    int guard;

    initial begin
        s_pix[0] = 24'hFFFFFF; s_pix[1] = 24'h010203;
        s_pix[2] = 24'h808080; s_pix[3] = 24'h7F7F7F;
        s_pix[4] = 24'h40C020; s_pix[5] = 24'h123456;
        s_pix[6] = 24'hABCDEF; s_pix[7] = 24'h000000;

        // ---- reset values ----
        #1;
        check("rst_request",   32'(s_req),   0);
        check("rst_orig_addr", 32'(s_oaddr), 0);
        check("rst_ready",     32'(s_irdy),  0);
        check("rst_out_addr",  32'(s_iaddr), 0);
        check("rst_out_data",  32'(s_idata), 0);
        check("rst_finish",    32'(s_fin),   0);
        check("rst_big_req",   32'(b_req),   0);
        @(posedge clk); @(posedge clk); #1;
        b_rst = 1'b0;
        s_rst = 1'b0;

        // ---- default frame, mode 0 ----
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        check("big_request_rise", 32'(b_req), 1);
        check("big_addr_start", 32'(b_oaddr), 0);
        big_cyc = 0;
        while (!b_fin && big_cyc < 20000) begin
            @(posedge clk); #1;
            big_cyc++;
        end
        check("big_finish_cycle", big_cyc, BN + 3);
        check("big_out_count", b_idx, BN);
        check("big_request_end", 32'(b_req), 0);
        check("big_addr_wrap", 32'(b_oaddr), 0);

        // ---- small: mode 1 from IDLE ----
        s_frame(2'd1, 1'b0);
        check("m1_request_rise", 32'(s_req0), 1);
        check("m1_addr_start", 32'(s_addr0), 0);
        check("m1_cycles", s_cyc, SN + 3);
        check("m1_white", 32'(s_out[0]), 32'h0FF);
        check("m1_010203", 32'(s_out[1]), 32'h001);
        for (int i = 0; i < SN; i++) check("m1_pixel", 32'(s_out[i]), 32'(ref_px(2'd1, s_pix[i])));

        // ---- small: mode 2, back-to-back from DONE ----
        s_frame(2'd2, 1'b0);
        check("m2_finish_drop", 32'(s_fin0), 0);
        check("m2_addr_restart", 32'(s_addr0), 0);
        check("m2_cycles", s_cyc, SN + 3);
        check("m2_40C020", 32'(s_out[4]), 32'h0C0);
        for (int i = 0; i < SN; i++) check("m2_pixel", 32'(s_out[i]), 32'(ref_px(2'd2, s_pix[i])));

        // ---- small: mode 3 with start and mode change during FETCH ----
        s_frame(2'd3, 1'b1);
        check("m3_cycles", s_cyc, SN + 3);
        check("m3_count", s_idx, SN);
        check("m3_808080", 32'(s_out[2]), 32'h0FF);
        check("m3_7F7F7F", 32'(s_out[3]), 32'h000);
        for (int i = 0; i < SN; i++) check("m3_pixel", 32'(s_out[i]), 32'(ref_px(2'd3, s_pix[i])));

        // ---- small: mode 0 with orig_ready withheld at address 5 ----
        s_stall = 1'b1;
        s_frame(2'd0, 1'b0);
        s_stall = 1'b0;
        check("stall_cycles", s_cyc, SN + 3 + 4);
        check("stall_addr5_zero", 32'(s_out[5]), 0);
        for (int i = 0; i < SN; i++)
            check("stall_pixel", 32'(s_out[i]), (i == 5) ? 32'd0 : 32'(ref_px(2'd0, s_pix[i])));

        // ---- small: asynchronous reset at pixel 3 ----
        s_idx  = 0;
        s_mode = 2'd1;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        guard = 0;
        while (s_oaddr != 3'd3 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_reach_pixel3", 32'(s_oaddr), 3);
        #2 s_rst = 1'b1;
        #1;
        check("mid_rst_request", 32'(s_req),   0);
        check("mid_rst_addr",    32'(s_oaddr), 0);
        check("mid_rst_ready",   32'(s_irdy),  0);
        check("mid_rst_oaddr",   32'(s_iaddr), 0);
        check("mid_rst_data",    32'(s_idata), 0);
        check("mid_rst_finish",  32'(s_fin),   0);
        @(posedge clk); #1 s_rst = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_irdy) rdy_seen++;
        end
        check("post_rst_no_ready", rdy_seen, 0);
        check("post_rst_idle", 32'(s_req), 0);

        s_frame(2'd0, 1'b0);
        check("after_rst_cycles", s_cyc, SN + 3);
        check("after_rst_count", s_idx, SN);
        for (int i = 0; i < SN; i++) check("after_rst_pixel", 32'(s_out[i]), 32'(ref_px(2'd0, s_pix[i])));

        @(posedge clk); #1;
        check("finish_held", 32'(s_fin), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
